vram_text_writer: RTL

//  Writer side of the text-mode VRAM: accepts a byte stream from the CPU and stores

---
 rtl/vram_text_writer_pkg.sv | 17 +
 rtl/vram_text_writer_if.sv | 26 ++
 rtl/vram_text_writer_block_mover.sv | 62 ++++++
 rtl/vram_text_writer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vram_text_writer_pkg.sv
// Shared definitions for the text-mode VRAM writer and the LCD scanout.
// Screen geometry defaults, control codes, blank fill code, writer state type.
package vram_text_writer_pkg;
  localparam int COLS    = 60;   // 480 px / 8
  localparam int ROWS    = 17;   // 272 px / 16
  localparam int VRAM_AW = 10;
  localparam int COL_W   = 6;
  localparam int ROW_W   = 5;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, FILL} wr_state_t;
endpackage

// File: rtl/vram_text_writer_if.sv
// Bus bundle of the VRAM text writer: CPU byte stream (valid/ready), VRAM
// port A (address, write data, write enable, read data) and status outputs
// (cursor position, busy). slave = writer block, master = its environment.
interface vram_text_writer_if
  import vram_text_writer_pkg::*;
#(parameter int AW = VRAM_AW);
  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;
  logic [AW-1:0]    v_ada;
  logic [7:0]       v_dina;
  logic             v_wea;
  logic [7:0]       v_douta;
  logic [COL_W-1:0] cursor_col;
  logic [ROW_W-1:0] cursor_row;
  logic             busy;

  modport slave (
    input  char_valid, char_data, v_douta,
    output char_ready, v_ada, v_dina, v_wea, cursor_col, cursor_row, busy
  );
  modport master (
    output char_valid, char_data, v_douta,
    input  char_ready, v_ada, v_dina, v_wea, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/vram_text_writer_block_mover.sv
// vram_block_mover: copy-or-fill engine over VRAM port A.
// Ports: clk/rst; i_start loads i_src/i_dst/i_len and i_fill (1 = fill with
// FILL_CODE, 0 = copy src->dst); i_rdata is port A read data (1-cycle latency).
// o_ada/o_dina/o_wea drive port A; o_done is high during the final write.
// Copy takes 2 cycles per cell (read, then write), fill 1 cycle per cell.
// A start during the final write reloads, so two jobs can run back to back.
module vram_block_mover
  import vram_text_writer_pkg::*;
#(
  parameter int         AW        = VRAM_AW,
  parameter logic [7:0] FILL_CODE = BLANK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_fill,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [AW-1:0] i_len,
  input  logic [7:0]    i_rdata,
  output logic [AW-1:0] o_ada,
  output logic [7:0]    o_dina,
  output logic          o_wea,
  output logic          o_done
);
  logic          r_act, r_fill, r_wr;
  logic [AW-1:0] r_src, r_dst, r_rem;
  logic          w_rd, w_wr;

  assign w_rd   = r_act & ~r_fill & ~r_wr;
  assign w_wr   = r_act & (r_fill | r_wr);
  assign o_done = w_wr & (r_rem == AW'(1));
  assign o_wea  = w_wr;
  assign o_ada  = w_rd ? r_src : (w_wr ? r_dst : '0);
  assign o_dina = ~w_wr ? 8'h00 : (r_fill ? FILL_CODE : i_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act  <= 1'b0;
      r_fill <= 1'b0;
      r_wr   <= 1'b0;
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
    end else if (i_start) begin
      r_act  <= 1'b1;
      r_fill <= i_fill;
      r_wr   <= 1'b0;
      r_src  <= i_src;
      r_dst  <= i_dst;
      r_rem  <= i_len;
    end else if (w_rd) begin
      r_wr <= 1'b1;
    end else if (w_wr) begin
      r_wr  <= 1'b0;
      r_src <= r_src + AW'(1);
      r_dst <= r_dst + AW'(1);
      r_rem <= r_rem - AW'(1);
      if (o_done) r_act <= 1'b0;
    end
  end
endmodule

// File: rtl/vram_text_writer.sv
// vram_text_writer: writer side of the text-mode VRAM.
// Ports: PixelClk (rising edge), RST (sync, active high), bus (slave modport):
// byte stream in (char_valid/char_data/char_ready), VRAM port A out
// (v_ada/v_dina/v_wea, v_douta in), cursor_col/cursor_row, busy.
// Printable bytes are written at the cursor; CR/LF/BS/FF move the cursor or
// clear the screen. Passing the last row scrolls the screen up one row using
// the block mover (copy rows 1..N-1 up, then blank the last row).
module vram_text_writer
  import vram_text_writer_pkg::*;
#(
  parameter int         NCOLS     = COLS,
  parameter int         NROWS     = ROWS,
  parameter int         AW        = VRAM_AW,
  parameter logic [7:0] FILL_CODE = BLANK
) (
  input  logic         PixelClk,
  input  logic         RST,
  vram_text_writer_if.slave bus
);
  localparam logic [AW-1:0]    A_COLS     = AW'(NCOLS);
  localparam logic [AW-1:0]    A_LAST_ROW = AW'((NROWS - 1) * NCOLS);
  localparam logic [AW-1:0]    A_CELLS    = AW'(NCOLS * NROWS);
  localparam logic [COL_W-1:0] C_LAST     = COL_W'(NCOLS - 1);
  localparam logic [ROW_W-1:0] R_LAST     = ROW_W'(NROWS - 1);

  wr_state_t        r_state, w_next;
  logic [7:0]       r_byte;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_clr;      // current FILL is a form feed (cursor homes at end)
  logic             w_hs;
  logic [AW-1:0]    w_put_ada;
  logic             w_mv_start, w_mv_fill, w_mv_wea, w_mv_done;
  logic [AW-1:0]    w_mv_src, w_mv_dst, w_mv_len, w_mv_ada;
  logic [7:0]       w_mv_dina;

  assign w_hs           = (r_state == IDLE) & bus.char_valid;
  assign w_put_ada      = AW'(r_row) * A_COLS + AW'(r_col);
  assign bus.cursor_col = r_col;
  assign bus.cursor_row = r_row;

  vram_block_mover #(.AW(AW), .FILL_CODE(FILL_CODE)) u_mover (
    .clk     (PixelClk),
    .rst     (RST),
    .i_start (w_mv_start),
    .i_fill  (w_mv_fill),
    .i_src   (w_mv_src),
    .i_dst   (w_mv_dst),
    .i_len   (w_mv_len),
    .i_rdata (bus.v_douta),
    .o_ada   (w_mv_ada),
    .o_dina  (w_mv_dina),
    .o_wea   (w_mv_wea),
    .o_done  (w_mv_done)
  );

  always_ff @(posedge PixelClk) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_hs) begin
        case (bus.char_data)
          CH_CR, CH_BS: w_next = IDLE;
          CH_LF:        w_next = (r_row == R_LAST) ? SCR_RD : IDLE;
          CH_FF:        w_next = FILL;
          default:      w_next = PUT;
        endcase
      end
      PUT:     w_next = (r_col == C_LAST && r_row == R_LAST) ? SCR_RD : IDLE;
      SCR_RD:  w_next = SCR_WR;
      SCR_WR:  w_next = w_mv_done ? FILL : SCR_RD;
      FILL:    if (w_mv_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The mover is kicked on the same edge that enters SCR_RD/FILL so its
  // read/write phases line up with the state register cycle for cycle.
  always_comb begin
    bus.char_ready = 1'b0;
    bus.busy       = 1'b0;
    bus.v_ada      = '0;
    bus.v_dina     = 8'h00;
    bus.v_wea      = 1'b0;
    w_mv_start     = 1'b0;
    w_mv_fill      = 1'b0;
    w_mv_src       = '0;
    w_mv_dst       = '0;
    w_mv_len       = '0;
    case (r_state)
      IDLE: bus.char_ready = 1'b1;
      PUT: begin
        bus.v_ada  = w_put_ada;
        bus.v_dina = r_byte;
        bus.v_wea  = 1'b1;
      end
      SCR_RD, SCR_WR, FILL: begin
        bus.busy   = 1'b1;
        bus.v_ada  = w_mv_ada;
        bus.v_dina = w_mv_dina;
        bus.v_wea  = w_mv_wea;
      end
      default: ;
    endcase
    if ((r_state == IDLE || r_state == PUT) && w_next == SCR_RD) begin
      w_mv_start = 1'b1;
      w_mv_src   = A_COLS;
      w_mv_len   = A_LAST_ROW;         // rows 1..N-1 move up one row
    end else if (r_state != FILL && w_next == FILL) begin
      w_mv_start = 1'b1;
      w_mv_fill  = 1'b1;
      w_mv_dst   = (r_state == SCR_WR) ? A_LAST_ROW : '0;
      w_mv_len   = (r_state == SCR_WR) ? A_COLS : A_CELLS;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      r_byte <= 8'h00;
      r_col  <= '0;
      r_row  <= '0;
      r_clr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_byte <= bus.char_data;
          case (bus.char_data)
            CH_CR: r_col <= '0;
            CH_BS: if (r_col != '0) r_col <= r_col - COL_W'(1);
            CH_LF: begin
              r_col <= '0;
              if (r_row != R_LAST) r_row <= r_row + ROW_W'(1);
            end
            CH_FF: r_clr <= 1'b1;
            default: ;
          endcase
        end
        PUT: begin
          if (r_col == C_LAST) begin
            r_col <= '0;
            if (r_row != R_LAST) r_row <= r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
        FILL: if (w_mv_done && r_clr) begin
          r_col <= '0;
          r_row <= '0;
          r_clr <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
